reg_file_nport: RTL and testbench

Parametrised multi-read-port register file that supersedes the fixed 8×8, two-read-port register file in the simple processor datapath. It provides one synchronous write port, `RD_PORTS` combinational read ports and a sequenced soft-clear engine that wipes the array one entry per cycle while reporting `BUSY`. An optional write-to-read bypass is compiled in by macro. It sits between instruction decode (addresses) and the ALU/operand muxes (`OUT`).

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_rd_port.sv | 30 +++
 rtl/reg_file_nport.sv | 100 ++++++++++
 tb/tb_reg_file_nport.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file.
// The REG_FILE_BYPASS_EN macro selects write-to-read bypass in the read ports.
package reg_file_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_e;

    localparam int RF_DATA_W   = 8;
    localparam int RF_ADDR_W   = 3;
    localparam int RF_RD_PORTS = 2;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: array mux plus an optional same-cycle write bypass
// (compiled in when REG_FILE_BYPASS_EN is defined).
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic [DATA_W-1:0] regs [DEPTH],
`ifdef REG_FILE_BYPASS_EN
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = regs[rd_addr];
`ifdef REG_FILE_BYPASS_EN
        // byp_en is only high for a write that will actually land this edge
        if (byp_en && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
`endif
    end

endmodule

// File: rtl/reg_file_nport.sv
// Register file: one synchronous write port, RD_PORTS combinational reads and a
// one-entry-per-cycle soft-clear engine. Optional bypass: REG_FILE_BYPASS_EN.
module reg_file_nport
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int RD_PORTS = RF_RD_PORTS
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         WRITE,
    input  logic [ADDR_W-1:0]            INADDRESS,
    input  logic [DATA_W-1:0]            IN,
    input  logic [RD_PORTS*ADDR_W-1:0]   OUTADDRESS,
    output logic [RD_PORTS*DATA_W-1:0]   OUT,
    input  logic                         CLEAR,
    output logic                         BUSY,
    output logic                         WR_DROP,
    output clr_state_e                   clr_state
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

    logic [DATA_W-1:0] regs [DEPTH];
    clr_state_e        state, state_next;
    logic [ADDR_W:0]   cptr, cptr_next;
    logic              wr_accept;
    logic              wr_dropped;

    assign wr_accept  = (state == IDLE) && WRITE && !CLEAR;
    assign wr_dropped = WRITE && ((state == CLEARING) || CLEAR);
    assign clr_state  = state;

    always_comb begin
        state_next = state;
        cptr_next  = cptr;
        case (state)
            IDLE: begin
                if (CLEAR) begin
                    state_next = CLEARING;
                    cptr_next  = '0;
                end
            end
            CLEARING: begin
                // CLEAR is ignored here; the sweep always runs to the last entry
                cptr_next = cptr + 1'b1;
                if (cptr == LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cptr    <= '0;
            BUSY    <= 1'b0;
            WR_DROP <= 1'b0;
        end else begin
            state   <= state_next;
            cptr    <= cptr_next;
            BUSY    <= (state_next == CLEARING);
            WR_DROP <= wr_dropped;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else if (state == CLEARING) begin
            regs[cptr[ADDR_W-1:0]] <= '0;
        end else if (wr_accept) begin
            regs[INADDRESS] <= IN;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rd (
            .regs    (regs),
`ifdef REG_FILE_BYPASS_EN
            .byp_en  (wr_accept && !RESET),
            .wr_addr (INADDRESS),
            .wr_data (IN),
`endif
            .rd_addr (OUTADDRESS[p*ADDR_W +: ADDR_W]),
            .rd_data (OUT[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_reg_file_nport.sv
// Self-checking bench for reg_file_nport: default 8x8/2-port instance plus a
// 16-bit, 16-entry, 3-port instance for the parametrised cases.
module tb_reg_file_nport;
    import reg_file_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst, write, clear, busy, wr_drop;
    logic [2:0]  inaddr;
    logic [7:0]  in_d;
    logic [5:0]  outaddr;
    logic [15:0] out_d;
    clr_state_e  state;

    // wide instance
    logic        rst2, write2, clear2, busy2, wr_drop2;
    logic [3:0]  inaddr2;
    logic [15:0] in2;
    logic [11:0] outaddr2;
    logic [47:0] out2;
    clr_state_e  state2;

    reg_file_nport u_dut (
        .CLK(clk), .RESET(rst), .WRITE(write), .INADDRESS(inaddr), .IN(in_d),
        .OUTADDRESS(outaddr), .OUT(out_d), .CLEAR(clear), .BUSY(busy),
        .WR_DROP(wr_drop), .clr_state(state)
    );

    reg_file_nport #(.DATA_W(16), .ADDR_W(4), .RD_PORTS(3)) u_dut2 (
        .CLK(clk), .RESET(rst2), .WRITE(write2), .INADDRESS(inaddr2), .IN(in2),
        .OUTADDRESS(outaddr2), .OUT(out2), .CLEAR(clear2), .BUSY(busy2),
        .WR_DROP(wr_drop2), .clr_state(state2)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got %0h, expected queue empty", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        write = 1'b1; inaddr = a; in_d = d;
        tick();
        write = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        rst = 1'b1; write = 1'b0; clear = 1'b0; inaddr = '0; in_d = '0; outaddr = '0;
        rst2 = 1'b1; write2 = 1'b0; clear2 = 1'b0; inaddr2 = '0; in2 = '0; outaddr2 = '0;
        tick();
        tick();
        rst = 1'b0; rst2 = 1'b0;

        // reset state: every address reads zero on both ports
        push(0); push(0);
        pop_check("rst_busy", {31'b0, busy});
        pop_check("rst_wr_drop", {31'b0, wr_drop});
        for (int a = 0; a < 8; a++) begin
            outaddr = {3'(a), 3'(a)};
            #1;
            push(0); push(0);
            pop_check("rst_p0", {16'b0, out_d[7:0]});
            pop_check("rst_p1", {16'b0, out_d[15:8]});
        end

        // basic write / read
        outaddr = {3'd1, 3'd2};
        write = 1'b1; inaddr = 3'd2; in_d = 8'd95;
        #1;
`ifdef REG_FILE_BYPASS_EN
        push(95);
`else
        push(0);
`endif
        pop_check("wr_cycle_p0", {24'b0, out_d[7:0]});
        tick();
        inaddr = 3'd1; in_d = 8'd28;
        push(95);
        pop_check("wr_r2_p0", {24'b0, out_d[7:0]});
        tick();
        write = 1'b0;
        push(95); push(28);
        pop_check("rd_r2_p0", {24'b0, out_d[7:0]});
        pop_check("rd_r1_p1", {24'b0, out_d[15:8]});

        // soft clear with a dropped write
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
        outaddr = {3'd7, 3'd3};
        #1;
        push(4); push(8);
        pop_check("fill_r3", {24'b0, out_d[7:0]});
        pop_check("fill_r7", {24'b0, out_d[15:8]});
        clear = 1'b1;
        tick();
        clear = 1'b0;
        busy_cnt = busy ? 1 : 0;
        push(1); push(0); push(4);
        pop_check("clr_t0_busy", {31'b0, busy});
        pop_check("clr_t0_drop", {31'b0, wr_drop});
        pop_check("clr_t0_r3", {24'b0, out_d[7:0]});
        for (int i = 1; i <= 8; i++) begin
            write = (i == 2); inaddr = 3'd7; in_d = 8'd50;
            push({31'b0, i < 8});
            push(i < 4 ? 4 : 0);
            push({31'b0, i == 2});
            tick();
            write = 1'b0;
            busy_cnt += busy ? 1 : 0;
            pop_check("clr_busy", {31'b0, busy});
            pop_check("clr_r3", {24'b0, out_d[7:0]});
            pop_check("clr_drop", {31'b0, wr_drop});
        end
        check("clr_busy_cycles", busy_cnt, 8);
        check("clr_r7_end", {24'b0, out_d[15:8]}, 0);
        check("clr_state_end", {31'b0, state}, {31'b0, IDLE});
        outaddr = {3'd7, 3'd6};
        wr(3'd6, 8'd66);
        check("post_clr_wr", {24'b0, out_d[7:0]}, 66);
        check("post_clr_drop", {31'b0, wr_drop}, 0);

        // simultaneous CLEAR and WRITE in IDLE
        outaddr = {3'd4, 3'd4};
        write = 1'b1; inaddr = 3'd4; in_d = 8'd15; clear = 1'b1;
        #1;
        check("cw_no_bypass", {24'b0, out_d[7:0]}, 0);
        tick();
        write = 1'b0; clear = 1'b0;
        check("cw_drop", {31'b0, wr_drop}, 1);
        check("cw_busy", {31'b0, busy}, 1);
        check("cw_r4", {24'b0, out_d[7:0]}, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("cw_drop_once", {31'b0, wr_drop}, 0);
            check("cw_r4_run", {24'b0, out_d[7:0]}, 0);
        end
        check("cw_busy_end", {31'b0, busy}, 0);

        // reset in the third CLEARING cycle
        wr(3'd5, 8'd55);
        wr(3'd7, 8'd77);
        outaddr = {3'd7, 3'd5};
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        check("mid_busy_pre", {31'b0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", {31'b0, busy}, 0);
        check("mid_drop", {31'b0, wr_drop}, 0);
        check("mid_state", {31'b0, state}, {31'b0, IDLE});
        for (int a = 0; a < 8; a++) begin
            outaddr = {3'(a), 3'(a)};
            #1;
            check("mid_zero", {16'b0, out_d}, 0);
        end
        outaddr = {3'd0, 3'd5};
        wr(3'd5, 8'd42);
        check("mid_wr_r5", {24'b0, out_d[7:0]}, 42);

        // wide instance: 16-bit data, 16 entries, 3 ports
        outaddr2 = {4'd15, 4'd15, 4'd15};
        write2 = 1'b1; inaddr2 = 4'd15; in2 = 16'hBEEF;
        tick();
        write2 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            push(32'h0000BEEF);
            pop_check("w_rd_port", {16'b0, out2[p*16 +: 16]});
        end
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && busy2; i++) begin
            busy_cnt++;
            tick();
        end
        check("w_busy_cycles", busy_cnt, 16);
        check("w_busy_end", {31'b0, busy2}, 0);
        check("w_r15_cleared", {16'b0, out2[15:0]}, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
